// File: rtl/bus_master_ctrl_if.sv
// Shared-bus signal bundle between a bus master sequencer and the arbiter/slave side.
// Active-low strobes keep their trailing underscore.
interface bus_master_ctrl_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/bus_master_ctrl.sv
// Per-master bus sequencer: turns a one-cycle access request into the arbiter
// request/grant handshake and an address-strobe/ready transfer with timeout abort.
module bus_master_ctrl #(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_en,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  bus_master_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              lat_rw_q, lat_rw_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wd_q, lat_wd_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_as_q, bus_as_d;
  logic              bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wd_q, bus_wd_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rdy_c, to_c, fin_c, abort_c;

  assign rdy_c = ~bus.bus_rdy_;
  assign to_c  = (cnt_q == TO_W'(TIMEOUT - 1));

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lat_rw_q   <= 1'b1;
      lat_addr_q <= '0;
      lat_wd_q   <= '0;
      bus_req_q  <= 1'b1;
      bus_as_q   <= 1'b1;
      bus_rw_q   <= 1'b1;
      bus_addr_q <= '0;
      bus_wd_q   <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_rw_q   <= lat_rw_d;
      lat_addr_q <= lat_addr_d;
      lat_wd_q   <= lat_wd_d;
      bus_req_q  <= bus_req_d;
      bus_as_q   <= bus_as_d;
      bus_rw_q   <= bus_rw_d;
      bus_addr_q <= bus_addr_d;
      bus_wd_q   <= bus_wd_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic; grant is only looked at while requesting
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_en) state_d = ST_REQ;
      ST_REQ:    if (!bus.bus_grnt_) state_d = ST_ACCESS;
      ST_ACCESS: state_d = rdy_c ? ST_IDLE : ST_WAIT;
      ST_WAIT:   if (rdy_c || to_c) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; ready beats a coincident timeout
  always_comb begin
    cnt_d      = cnt_q;
    lat_rw_d   = lat_rw_q;
    lat_addr_d = lat_addr_q;
    lat_wd_d   = lat_wd_q;
    bus_req_d  = bus_req_q;
    bus_as_d   = bus_as_q;
    bus_rw_d   = bus_rw_q;
    bus_addr_d = bus_addr_q;
    bus_wd_d   = bus_wd_q;
    rd_data_d  = rd_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fin_c      = 1'b0;
    abort_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_en) begin
          lat_rw_d   = rw;
          lat_addr_d = addr;
          lat_wd_d   = wr_data;
          bus_req_d  = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_REQ: begin
        if (!bus.bus_grnt_) begin
          bus_as_d   = 1'b0;
          bus_rw_d   = lat_rw_q;
          bus_addr_d = lat_addr_q;
          bus_wd_d   = lat_wd_q;
        end
      end
      ST_ACCESS: begin
        if (rdy_c) begin
          fin_c = 1'b1;
        end else begin
          bus_as_d = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_WAIT: begin
        if (rdy_c)     fin_c   = 1'b1;
        else if (to_c) abort_c = 1'b1;
        else           cnt_d   = cnt_q + TO_W'(1);
      end
      default: ;
    endcase

    // Completion and abort both release the bus and return to idle
    if (fin_c || abort_c) begin
      done_d     = 1'b1;
      busy_d     = 1'b0;
      bus_req_d  = 1'b1;
      bus_as_d   = 1'b1;
      bus_addr_d = '0;
      bus_wd_d   = '0;
      if (abort_c) begin
        rd_data_d = '0;
        err_d     = 1'b1;
      end else if (lat_rw_q) begin
        rd_data_d = bus.bus_rd_data;
      end
    end
  end

  assign rd_data         = rd_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign bus.bus_req_    = bus_req_q;
  assign bus.bus_as_     = bus_as_q;
  assign bus.bus_rw      = bus_rw_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_wr_data = bus_wd_q;

endmodule
